i2s_audio_tx: RTL and testbench

//  Serialises the VirtualToplevel's signed 16-bit stereo audio (audio_l/audio_r) into

---
 rtl/i2s_audio_tx.sv | 87 ++++++++
 tb/tb_i2s_audio_tx.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx: serialises a signed stereo sample pair into Philips I2S with an internally divided BCLK/LRCLK.
module i2s_audio_tx #(
  parameter int BCLK_HALF    = 16,
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] audio_l,
  input  logic [SAMPLE_WIDTH-1:0] audio_r,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    underrun,
  output logic                    i2s_bclk,
  output logic                    i2s_lrclk,
  output logic                    i2s_data
);
  localparam int HW = BCLK_HALF > 1 ? $clog2(BCLK_HALF) : 1;
  localparam int BW = $clog2(2 * SLOT_WIDTH);
  localparam int IW = SAMPLE_WIDTH > 1 ? $clog2(SAMPLE_WIDTH) : 1;
  localparam logic [BW-1:0] LAST = BW'(2 * SLOT_WIDTH - 1);
  logic [HW-1:0] halfcnt_q, halfcnt_d;
  logic [BW-1:0] bitcnt_q, bitcnt_d, n;
  logic [IW-1:0] k;
  logic bclk_q, bclk_d, lrclk_q, lrclk_d, data_q, data_d;
  logic full_q, full_d, ready_q, ready_d, underrun_q, underrun_d;
  logic tick, fall, wrap, accept;
  logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [SAMPLE_WIDTH-1:0] shift_l_q, shift_l_d, shift_r_q, shift_r_d, word;
  always_comb begin
    tick       = halfcnt_q == HW'(BCLK_HALF - 1);
    fall       = tick & bclk_q;
    wrap       = fall & (bitcnt_q == LAST);
    accept     = sample_valid & ready_q;
    halfcnt_d  = tick ? '0 : halfcnt_q + 1'b1;
    bclk_d     = bclk_q ^ tick;
    bitcnt_d   = fall ? (wrap ? '0 : bitcnt_q + 1'b1) : bitcnt_q;
    hold_l_d   = accept ? audio_l : hold_l_q;
    hold_r_d   = accept ? audio_r : hold_r_q;
    // full_q is the pre-cycle value, so a same-cycle accept waits for the next frame
    full_d     = accept | (full_q & ~wrap);
    ready_d    = ~full_d;
    underrun_d = wrap & ~full_q;
    shift_l_d  = (wrap & full_q) ? hold_l_q : shift_l_q;
    shift_r_d  = (wrap & full_q) ? hold_r_q : shift_r_q;
    lrclk_d    = bitcnt_d >= BW'(SLOT_WIDTH);
    n          = lrclk_d ? bitcnt_d - BW'(SLOT_WIDTH) : bitcnt_d;
    k          = IW'(SAMPLE_WIDTH) - n[IW-1:0];
    word       = lrclk_d ? shift_r_d : shift_l_d;
    // slot bit 0 is the I2S one-BCLK delay after the LRCLK edge
    data_d     = (n != '0 && n <= BW'(SAMPLE_WIDTH)) ? word[k] : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      halfcnt_q  <= '0;
      bclk_q     <= 1'b0;
      bitcnt_q   <= '0;
      lrclk_q    <= 1'b0;
      data_q     <= 1'b0;
      full_q     <= 1'b0;
      ready_q    <= 1'b0;
      underrun_q <= 1'b0;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      shift_l_q  <= '0;
      shift_r_q  <= '0;
    end else begin
      halfcnt_q  <= halfcnt_d;
      bclk_q     <= bclk_d;
      bitcnt_q   <= bitcnt_d;
      lrclk_q    <= lrclk_d;
      data_q     <= data_d;
      full_q     <= full_d;
      ready_q    <= ready_d;
      underrun_q <= underrun_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      shift_l_q  <= shift_l_d;
      shift_r_q  <= shift_r_d;
    end
  end
  assign sample_ready = ready_q;
  assign underrun     = underrun_q;
  assign i2s_bclk     = bclk_q;
  assign i2s_lrclk    = lrclk_q;
  assign i2s_data     = data_q;
endmodule

// File: tb/tb_i2s_audio_tx.sv
// tb_i2s_audio_tx: scoreboarded I2S frame checks for the default slot layout and a short-slot variant.
module tb_i2s_audio_tx;
  typedef struct {logic [15:0] l; logic [15:0] r; logic ur;} ent_t;
  logic clk = 0, reset = 1;
  logic [15:0] audio_l = 0, audio_r = 0, l6 = 0, r6 = 0;
  logic sample_valid = 0, v6 = 0;
  logic sample_ready, underrun, i2s_bclk, i2s_lrclk, i2s_data;
  logic ready6, ur6, bclk6, lr6, d6;
  int cyc = 0, npass = 0, ntot = 0, p0 = 0, p6 = 0, idx = 0;
  bit phase6 = 1;
  ent_t exp_q[$];
  ent_t cur = '{16'h0, 16'h0, 1'b0};
  ent_t e6 = '{16'h0, 16'h0, 1'b0};
  logic [31:0] vals [4] = '{32'h1234ABCD, 32'h5A5AC3C3, 32'h0F0F8000, 32'h0};

  i2s_audio_tx #(.BCLK_HALF(2), .SAMPLE_WIDTH(16), .SLOT_WIDTH(32)) u0 (
    .clk(clk), .reset(reset), .audio_l(audio_l), .audio_r(audio_r),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .underrun(underrun),
    .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_data(i2s_data));

  i2s_audio_tx #(.BCLK_HALF(1), .SAMPLE_WIDTH(16), .SLOT_WIDTH(17)) u6 (
    .clk(clk), .reset(reset), .audio_l(l6), .audio_r(r6),
    .sample_valid(v6), .sample_ready(ready6), .underrun(ur6),
    .i2s_bclk(bclk6), .i2s_lrclk(lr6), .i2s_data(d6));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s cyc=%0d got %h expected %h", name, cyc, act, exp);
  endtask

  function automatic logic bit_of(input ent_t e, input int p, input int slot);
    int n = p % slot;
    logic [15:0] w = (p >= slot) ? e.r : e.l;
    return (n >= 1 && n <= 16) ? w[16-n] : 1'b0;
  endfunction

  task automatic go(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) if (!reset && cyc > 0) begin
    chk("bclk", 16'(i2s_bclk), 16'((cyc / 2) % 2));
    if (cyc % 4 == 2) begin
      p0 = ((cyc - 2) / 4) % 64;
      if (p0 == 0) begin
        if (exp_q.size() == 0) begin
          ntot++;
          $display("FAIL frame_pop cyc=%0d got empty queue expected an entry", cyc);
        end else cur = exp_q.pop_front();
      end
      chk("lrclk", 16'(i2s_lrclk), 16'(p0 >= 32));
      chk("data", 16'(i2s_data), 16'(bit_of(cur, p0, 32)));
    end
    if (cyc % 256 == 0) begin
      if (exp_q.size() == 0) begin
        ntot++;
        $display("FAIL underrun_peek cyc=%0d got empty queue expected an entry", cyc);
      end else chk("underrun_wrap", 16'(underrun), 16'(exp_q[0].ur));
    end else if (underrun) chk("underrun_spurious", 16'(underrun), 16'h0);
  end

  always @(negedge clk) if (!reset && cyc > 0 && cyc < 204 && phase6) begin
    chk("bclk6", 16'(bclk6), 16'(cyc % 2));
    if (cyc % 2 == 1) begin
      p6 = ((cyc - 1) / 2) % 34;
      e6 = (((cyc - 1) / 2) >= 34) ? ent_t'{16'h8001, 16'h7FFE, 1'b0} : ent_t'{16'h0, 16'h0, 1'b0};
      chk("lrclk6", 16'(lr6), 16'(p6 >= 17));
      chk("data6", 16'(d6), 16'(bit_of(e6, p6, 17)));
    end
    if (cyc % 68 == 0) chk("underrun6", 16'(ur6), 16'(cyc == 136));
    else if (ur6) chk("underrun6_spurious", 16'(ur6), 16'h0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got no finish expected finish", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bclk", 16'(i2s_bclk), 16'h0);
    chk("rst_lrclk", 16'(i2s_lrclk), 16'h0);
    chk("rst_data", 16'(i2s_data), 16'h0);
    chk("rst_ready", 16'(sample_ready), 16'h0);
    chk("rst_underrun", 16'(underrun), 16'h0);
    exp_q.push_back(ent_t'{16'h0, 16'h0, 1'b0});
    reset = 0;
    go(1);
    chk("ready_after_rst", 16'(sample_ready), 16'h1);
    go(5);
    v6 = 1; l6 = 16'h8001; r6 = 16'h7FFE;
    go(6);
    v6 = 0;
    go(10);
    sample_valid = 1; audio_l = 16'h8001; audio_r = 16'h7FFE;
    exp_q.push_back(ent_t'{16'h8001, 16'h7FFE, 1'b0});
    go(11);
    sample_valid = 0;
    chk("ready_after_accept", 16'(sample_ready), 16'h0);
    go(300);
    exp_q.push_back(ent_t'{16'h8001, 16'h7FFE, 1'b1});
    go(532);
    sample_valid = 1;
    {audio_l, audio_r} = vals[0];
    idx = 0;
    while (idx < 3) begin
      if (cyc % 256 == 0) chk("ready_wrap", 16'(sample_ready), 16'h1);
      if (cyc % 256 == 128) chk("ready_mid", 16'(sample_ready), 16'h0);
      if (sample_ready) begin
        exp_q.push_back(ent_t'{audio_l, audio_r, 1'b0});
        idx++;
        @(posedge clk);
        #1;
        {audio_l, audio_r} = vals[idx];
      end else begin
        @(posedge clk);
        #1;
      end
    end
    sample_valid = 0;
    exp_q.push_back(ent_t'{vals[2][31:16], vals[2][15:0], 1'b1});
    go(1540);
    sample_valid = 1; audio_l = 16'hDEAD; audio_r = 16'hBEEF;
    go(1541);
    sample_valid = 0;
    chk("ready_full_pre_rst", 16'(sample_ready), 16'h0);
    go(1696);
    reset = 1;
    phase6 = 0;
    @(posedge clk);
    #1;
    chk("mid_rst_bclk", 16'(i2s_bclk), 16'h0);
    chk("mid_rst_lrclk", 16'(i2s_lrclk), 16'h0);
    chk("mid_rst_data", 16'(i2s_data), 16'h0);
    chk("mid_rst_ready", 16'(sample_ready), 16'h0);
    chk("mid_rst_underrun", 16'(underrun), 16'h0);
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    exp_q.push_back(ent_t'{16'h0, 16'h0, 1'b0});
    exp_q.push_back(ent_t'{16'h0, 16'h0, 1'b1});
    reset = 0;
    go(1);
    chk("ready_after_mid_rst", 16'(sample_ready), 16'h1);
    go(511);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
